// File: rtl/latch_pkg.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : latch_pkg
// Description : Shared constants for the MouseTrap master-slave latch pair.
// Revision    : 1.0 - initial release
// ============================================================================
package latch_pkg;

  // Default data path width of one latch stage
  localparam int LATCH_DEFAULT_WIDTH = 1;

  // Per-bit reset value; replicated to the data path width by users
  localparam logic LATCH_RST_VAL = 1'b0;

endpackage : latch_pkg
`default_nettype wire

// File: rtl/latch_dir.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : latch_dir
// Description : WIDTH-bit level-sensitive transparent latch with asynchronous
//               active-high reset to zero. Transparent while Enable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_dir
  import latch_pkg::*;
#(
  parameter int WIDTH = LATCH_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] D,
  input  logic             Enable,
  input  logic             Reset,
  output logic [WIDTH-1:0] Q
);

  // Reset has priority; otherwise pass D through while open, hold while closed
  always_latch begin
    if (Reset) begin
      Q <= {WIDTH{LATCH_RST_VAL}};
    end else if (Enable) begin
      Q <= D;
    end
  end

endmodule : latch_dir
`default_nettype wire

// File: rtl/latch_verilog.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : latch_verilog
// Description : Falling-edge master-slave register built from two transparent
//               latches on opposite Enable phases; storage primitive of the
//               MouseTrap asynchronous pipeline stage.
//               Optional feature macro: LATCH_VERILOG_CELEMENT_EN adds the
//               Req/Ack ports and a Muller C-element acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_verilog
  import latch_pkg::*;
#(
  parameter int WIDTH = LATCH_DEFAULT_WIDTH
) (
  input  logic             Enable,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
`ifdef LATCH_VERILOG_CELEMENT_EN
  ,
  input  logic             Req,
  output logic             Ack
`endif
);

  // Slave opens on the low phase so Q2 only ever sees the master's output,
  // never Data directly.
  logic w_slave_en;
  assign w_slave_en = ~Enable;

  // Master: transparent while Enable is high
  latch_dir #(
    .WIDTH (WIDTH)
  ) u_master (
    .D      (Data),
    .Enable (Enable),
    .Reset  (Reset),
    .Q      (Q1)
  );

  // Slave: transparent while Enable is low, fed from the master
  latch_dir #(
    .WIDTH (WIDTH)
  ) u_slave (
    .D      (Q1),
    .Enable (w_slave_en),
    .Reset  (Reset),
    .Q      (Q2)
  );

`ifdef LATCH_VERILOG_CELEMENT_EN
  // Muller C-element: follow the inputs when they agree, hold when they differ
  always_latch begin
    if (Reset) begin
      Ack <= LATCH_RST_VAL;
    end else if (Req == Enable) begin
      Ack <= Req;
    end
  end
`endif

endmodule : latch_verilog
`default_nettype wire

// File: tb/tb_latch_verilog.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_latch_verilog
// Description : Self-checking bench for latch_verilog: directed sequence from
//               the block's intended behaviour followed by random stimulus
//               against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_verilog;

  localparam int W = 8;

  logic         Enable;
  logic         Reset;
  logic [W-1:0] Data;
  logic [W-1:0] Q1;
  logic [W-1:0] Q2;
`ifdef LATCH_VERILOG_CELEMENT_EN
  logic         Req;
  logic         Ack;
  logic         m_ack;
`endif

  // Reference model: the value captured at the most recent falling edge of
  // Enable since the last reset. Q2 always shows it; Q1 shows Data while the
  // master is open and the captured value otherwise.
  logic [W-1:0] m_cap;

  int n_tests = 0;
  int n_fail  = 0;

  latch_verilog #(
    .WIDTH (W)
  ) dut (
    .Enable (Enable),
    .Reset  (Reset),
    .Data   (Data),
    .Q1     (Q1),
    .Q2     (Q2)
`ifdef LATCH_VERILOG_CELEMENT_EN
    ,
    .Req    (Req),
    .Ack    (Ack)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // C-element rule from the acknowledge definition
  task automatic model_ack();
`ifdef LATCH_VERILOG_CELEMENT_EN
    if (Reset) m_ack = 1'b0;
    else if (Req == Enable) m_ack = Req;
`endif
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e_q1;
    logic [W-1:0] e_q2;
    e_q1 = Reset ? '0 : (Enable ? Data : m_cap);
    e_q2 = Reset ? '0 : m_cap;
    check({tag, ".Q1"}, 32'(Q1), 32'(e_q1));
    check({tag, ".Q2"}, 32'(Q2), 32'(e_q2));
`ifdef LATCH_VERILOG_CELEMENT_EN
    check({tag, ".Ack"}, 32'(Ack), 32'(m_ack));
`endif
  endtask

  // Each stimulus step changes one input, settles, checks mid-step, then waits
  task automatic set_en(input logic v, input string tag);
    if (Enable && !v && !Reset) m_cap = Data;
    Enable = v;
    model_ack();
    #0.5;
    check_all(tag);
    #0.5;
  endtask

  task automatic set_data(input logic [W-1:0] v, input string tag);
    Data = v;
    #0.5;
    check_all(tag);
    #0.5;
  endtask

  task automatic set_rst(input logic v, input string tag);
    Reset = v;
    if (v) m_cap = '0;
    model_ack();
    #0.5;
    check_all(tag);
    #0.5;
  endtask

`ifdef LATCH_VERILOG_CELEMENT_EN
  task automatic set_req(input logic v, input string tag);
    Req = v;
    model_ack();
    #0.5;
    check_all(tag);
    #0.5;
  endtask
`endif

  // Enable is the stage clock; it is driven as an explicit waveform here
  initial begin
    Reset  = 1'b1;
    Enable = 1'b0;
    Data   = '0;
    m_cap  = '0;
`ifdef LATCH_VERILOG_CELEMENT_EN
    Req    = 1'b0;
    m_ack  = 1'b0;
`endif

    // Reset held: everything stays at zero
    #10;  check_all("rst_10");
    #50;  check_all("rst_60");
    #39.5; check_all("rst_99");
    #0.5;

    // t=100: release reset with the master open and Data=1
    Reset  = 1'b0;
    Enable = 1'b1;
    Data   = 8'h01;
    model_ack();
    #0.2;
    check(  "rel.Q1", 32'(Q1), 32'h01);
    check(  "rel.Q2", 32'(Q2), 32'h00);
    #0.8;

    // t=101: falling edge captures 1; t=101.5 Data drops, nothing follows
    m_cap  = 8'h01;
    Enable = 1'b0;
    model_ack();
    #0.2;
    check("fall.Q2", 32'(Q2), 32'h01);
    #0.3;
    Data = 8'h00;
    #0.2;
    check("hold.Q1", 32'(Q1), 32'h01);
    check("hold.Q2", 32'(Q2), 32'h01);
    #0.3;

    // Enable low: Data toggling is invisible on both outputs
    set_data(8'hA5, "lo_d1");
    set_data(8'h00, "lo_d0");

    // Reset pulse while master open: drop to 0, Q1 recovers after release
    set_en(1'b1, "open");
    set_data(8'h01, "open_d");
    set_rst(1'b1, "pulse");
    set_rst(1'b0, "unpulse");
    check("recover.Q1", 32'(Q1), 32'h01);

`ifdef LATCH_VERILOG_CELEMENT_EN
    // C-element handshake sequence
    set_en(1'b0, "c_lo");
    set_req(1'b1, "c_req1");
    check("c_req1_ack", 32'(Ack), 32'h0);
    set_en(1'b1, "c_en1");
    check("c_both1_ack", 32'(Ack), 32'h1);
    set_req(1'b0, "c_req0");
    check("c_hold_ack", 32'(Ack), 32'h1);
    set_en(1'b0, "c_en0");
    check("c_both0_ack", 32'(Ack), 32'h0);
    set_req(1'b1, "c_r1");
    set_en(1'b1, "c_e1");
    set_rst(1'b1, "c_rst");
    check("c_rst_ack", 32'(Ack), 32'h0);
    set_rst(1'b0, "c_unrst");
`endif

    // Random stimulus: one input change per step, never Data and Enable together
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        set_en(~Enable, "rnd_en");
      end else if (sel <= 6) begin
        set_data(W'($urandom), "rnd_d");
      end else if (sel == 7) begin
        set_rst(1'b1, "rnd_rst");
        if ($urandom_range(0, 1) == 1) set_en(~Enable, "rnd_en_in_rst");
        set_rst(1'b0, "rnd_unrst");
      end else begin
`ifdef LATCH_VERILOG_CELEMENT_EN
        set_req(~Req, "rnd_req");
`else
        set_data(W'($urandom), "rnd_d2");
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_latch_verilog
`default_nettype wire
